// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-layer post-processing stages.
package bnn_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned PACK_W     = 32;
   localparam int unsigned POS_W      = 5;

   // Controller state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Per-job batch-norm settings captured at launch
   typedef struct packed {
      logic [31:0] thr;
      logic        inv;
   } bn_cfg_t;

   // Folded batch-norm sign: ties count as positive, then optional flip
   function automatic logic bn_sign_bit(input logic [31:0] data,
                                        input logic [31:0] thr,
                                        input logic        inv);
      return ($signed(data) >= $signed(thr)) ^ inv;
   endfunction

endpackage

// File: rtl/bit_packer32.sv
// Collects one bit per valid cycle, LSB-first, and emits a 32-bit word
// when the word fills or the last bit of the job arrives.
module bit_packer32
   import bnn_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic              i_bit,
   input  logic              i_last,
   output logic              o_flush_c,
   output logic              o_word_valid,
   output logic              o_word_last,
   output logic [PACK_W-1:0] o_word
);

   logic [PACK_W-1:0] r_shift;
   logic [POS_W-1:0]  r_pos;
   logic [PACK_W-1:0] w_merged;

   // Current accumulator with the incoming bit placed at its position
   always_comb begin
      w_merged        = r_shift;
      w_merged[r_pos] = i_bit;
   end

   assign o_flush_c = i_valid & ((r_pos == POS_W'(PACK_W - 1)) | i_last);

   // Accumulate bits; on flush present the word for one cycle and restart
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift      <= '0;
         r_pos        <= '0;
         o_word_valid <= 1'b0;
         o_word_last  <= 1'b0;
         o_word       <= '0;
      end else begin
         o_word_valid <= o_flush_c;
         o_word_last  <= o_flush_c & i_last;
         o_word       <= o_flush_c ? w_merged : '0;
         if (o_flush_c) begin
            r_shift <= '0;
            r_pos   <= '0;
         end else if (i_valid) begin
            r_shift <= w_merged;
            r_pos   <= r_pos + POS_W'(1);
         end
      end
   end

endmodule

// File: rtl/bn_sign_pack.sv
// Streams signed conv results from BRAM, thresholds them into sign bits
// and writes the packed bits to the activation BRAM.
module bn_sign_pack
   import bnn_pkg::*;
#(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned N_MAX = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             ready,
   output logic             done,
   input  logic [CNT_W-1:0] count,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [31:0]      threshold,
   input  logic             invert,
   output logic             clka,
   output logic             ena,
   output logic [31:0]      addra,
   input  logic [31:0]      douta,
   output logic             clkb,
   output logic             enb,
   output logic [31:0]      addrb,
   output logic [31:0]      dinb,
   output logic [3:0]       web
);

   logic [1:0]       r_state;
   logic             r_start_q;
   logic [CNT_W-1:0] r_left;
   logic [31:0]      r_addra;
   logic             r_ena;
   logic             r_rvalid;
   logic             r_rlast;
   logic [31:0]      r_wptr;
   logic [31:0]      r_addrb;
   logic             r_ready;
   logic             r_done;
   bn_cfg_t          r_cfg;

   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_left_nxt;
   logic [31:0]      w_addra_nxt;
   logic             w_ena_nxt;
   logic [31:0]      w_wptr_nxt;
   logic [31:0]      w_addrb_nxt;
   logic             w_ready_nxt;
   logic             w_done_nxt;
   bn_cfg_t          w_cfg_nxt;

   logic             w_start_rise;
   logic [CNT_W-1:0] w_n;
   logic             w_bit;
   logic             w_flush_c;
   logic             w_word_valid;
   logic             w_word_last;
   logic [31:0]      w_word;

   assign w_start_rise = start & ~r_start_q;
   assign w_n          = (count > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : count;
   assign w_bit        = bn_sign_bit(douta, r_cfg.thr, r_cfg.inv);

   // Next-state and next-output values for the job controller
   always_comb begin
      w_state_nxt = r_state;
      w_left_nxt  = r_left;
      w_addra_nxt = '0;
      w_ena_nxt   = 1'b0;
      w_wptr_nxt  = r_wptr;
      w_addrb_nxt = '0;
      w_ready_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      w_cfg_nxt   = r_cfg;

      case (r_state)
         ST_IDLE: begin
            w_ready_nxt = 1'b1;
            if (w_start_rise) begin
               w_cfg_nxt.thr = threshold;
               w_cfg_nxt.inv = invert;
               w_wptr_nxt    = dst_addr;
               w_ready_nxt   = 1'b0;
               if (w_n == '0) begin
                  w_state_nxt = ST_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_READ;
                  w_ena_nxt   = 1'b1;
                  w_addra_nxt = src_addr;
                  w_left_nxt  = w_n - CNT_W'(1);
               end
            end
         end
         ST_READ: begin
            if (r_left == '0) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_ena_nxt   = 1'b1;
               w_addra_nxt = r_addra + 32'(WORD_BYTES);
               w_left_nxt  = r_left - CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (w_word_last) begin
               w_state_nxt = ST_DONE;
               w_done_nxt  = 1'b1;
               w_ready_nxt = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_ready_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ready_nxt = 1'b1;
         end
      endcase

      // Write address travels alongside the word the packer is about to emit
      if (w_flush_c) begin
         w_addrb_nxt = r_wptr;
         w_wptr_nxt  = r_wptr + 32'(WORD_BYTES);
      end
   end

   // State and registered outputs; read-valid tracks the 1-cycle BRAM latency
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_start_q <= 1'b0;
         r_left    <= '0;
         r_addra   <= '0;
         r_ena     <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_wptr    <= '0;
         r_addrb   <= '0;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_cfg     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_start_q <= start;
         r_left    <= w_left_nxt;
         r_addra   <= w_addra_nxt;
         r_ena     <= w_ena_nxt;
         r_rvalid  <= r_ena;
         r_rlast   <= r_ena & (r_left == '0);
         r_wptr    <= w_wptr_nxt;
         r_addrb   <= w_addrb_nxt;
         r_ready   <= w_ready_nxt;
         r_done    <= w_done_nxt;
         r_cfg     <= w_cfg_nxt;
      end
   end

   bit_packer32 u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (r_rvalid),
      .i_bit        (w_bit),
      .i_last       (r_rlast),
      .o_flush_c    (w_flush_c),
      .o_word_valid (w_word_valid),
      .o_word_last  (w_word_last),
      .o_word       (w_word)
   );

   assign clka  = clk;
   assign clkb  = clk;
   assign ready = r_ready;
   assign done  = r_done;
   assign ena   = r_ena;
   assign addra = r_addra;
   assign enb   = w_word_valid;
   assign addrb = r_addrb;
   assign dinb  = w_word;
   assign web   = {4{w_word_valid}};

endmodule
